// File: rtl/amo_rmw_sequencer.sv
// Sequences one M_* memory command at a time: loads/stores pass through, AMOs read-modify-write, LR/SC use a timed reservation.
// Latency from accept (c0), ready memory with 1-cycle response: load/store/SC-hit c3, AMO c5, SC-miss and no-access commands c1.
// Backpressure: req_ready only while idle; mem_req_* held until mem_req_ready, resp_* held until resp_ready.
module amo_rmw_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int LRSC_CYCLES = 80
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_cmd,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [DATA_W/8-1:0] req_mask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_write,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_data,
  output logic [DATA_W/8-1:0] mem_req_mask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  input  logic                inval_valid,
  input  logic [ADDR_W-1:0]   inval_addr
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(LRSC_CYCLES + 1);

  localparam logic [4:0] M_XRD      = 5'b00000;
  localparam logic [4:0] M_XWR      = 5'b00001;
  localparam logic [4:0] M_XA_SWAP  = 5'b00100;
  localparam logic [4:0] M_XLR      = 5'b00110;
  localparam logic [4:0] M_XSC      = 5'b00111;
  localparam logic [4:0] M_XA_ADD   = 5'b01000;
  localparam logic [4:0] M_XA_XOR   = 5'b01001;
  localparam logic [4:0] M_XA_OR    = 5'b01010;
  localparam logic [4:0] M_XA_AND   = 5'b01011;
  localparam logic [4:0] M_XA_MIN   = 5'b01100;
  localparam logic [4:0] M_XA_MAX   = 5'b01101;
  localparam logic [4:0] M_XA_MINU  = 5'b01110;
  localparam logic [4:0] M_XA_MAXU  = 5'b01111;
  localparam logic [4:0] M_PWR      = 5'b10001;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t              state;
  logic [4:0]          cmd_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   old_q;
  logic [DATA_W-1:0]   amo_new;

  logic                resv_valid;
  logic [ADDR_W-1:0]   resv_addr;
  logic [CNT_W-1:0]    resv_cnt;

  logic                accept;
  logic                resv_hit;
  logic                sc_accept;
  logic                lr_set;
  logic                inval_lr;
  logic                inval_resv;

  function automatic logic is_amo(input logic [4:0] c);
    case (c)
      M_XA_SWAP, M_XA_ADD, M_XA_XOR, M_XA_OR, M_XA_AND,
      M_XA_MIN, M_XA_MAX, M_XA_MINU, M_XA_MAXU: is_amo = 1'b1;
      default:                                  is_amo = 1'b0;
    endcase
  endfunction

  // Reservations track whole words, so drop the byte offset.
  function automatic logic [ADDR_W-1:0] word_al(input logic [ADDR_W-1:0] a);
    word_al = a & ~ADDR_W'(MASK_W - 1);
  endfunction

  assign accept     = (state == IDLE) && req_valid && req_ready;
  assign resv_hit   = resv_valid && (word_al(req_addr) == resv_addr);
  assign sc_accept  = accept && (req_cmd == M_XSC);
  assign lr_set     = (state == RD_WAIT) && mem_resp_valid && (cmd_q == M_XLR);
  assign inval_lr   = inval_valid && (word_al(inval_addr) == word_al(mem_req_addr));
  assign inval_resv = inval_valid && resv_valid && (word_al(inval_addr) == resv_addr);

  // New memory word for an AMO: a = returning old value, b = captured operand.
  always_comb begin
    amo_new = data_q;
    case (cmd_q)
      M_XA_ADD:  amo_new = mem_resp_data + data_q;
      M_XA_XOR:  amo_new = mem_resp_data ^ data_q;
      M_XA_OR:   amo_new = mem_resp_data | data_q;
      M_XA_AND:  amo_new = mem_resp_data & data_q;
      M_XA_MIN:  amo_new = ($signed(mem_resp_data) < $signed(data_q)) ? mem_resp_data : data_q;
      M_XA_MAX:  amo_new = ($signed(mem_resp_data) > $signed(data_q)) ? mem_resp_data : data_q;
      M_XA_MINU: amo_new = (mem_resp_data < data_q) ? mem_resp_data : data_q;
      M_XA_MAXU: amo_new = (mem_resp_data > data_q) ? mem_resp_data : data_q;
      default:   amo_new = data_q;
    endcase
  end

  // Main sequencer: state plus every registered output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_mask  <= '0;
      cmd_q         <= '0;
      data_q        <= '0;
      old_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready    <= 1'b0;
            cmd_q        <= req_cmd;
            data_q       <= req_data;
            mem_req_addr <= req_addr;
            if (req_cmd == M_XRD || req_cmd == M_XLR || is_amo(req_cmd)) begin
              state         <= RD_REQ;
              mem_req_valid <= 1'b1;
              mem_req_write <= 1'b0;
              mem_req_data  <= '0;
              mem_req_mask  <= '1;
            end else if (req_cmd == M_XWR || req_cmd == M_PWR ||
                         (req_cmd == M_XSC && resv_hit)) begin
              state         <= WR_REQ;
              mem_req_valid <= 1'b1;
              mem_req_write <= 1'b1;
              mem_req_data  <= req_data;
              mem_req_mask  <= req_mask;
            end else begin
              // Failed SC reports 1; maintenance/prefetch/unknown report 0.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= (req_cmd == M_XSC) ? DATA_W'(1) : '0;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_resp_valid) begin
            old_q <= mem_resp_data;
            if (is_amo(cmd_q)) begin
              state         <= WR_REQ;
              mem_req_valid <= 1'b1;
              mem_req_write <= 1'b1;
              mem_req_data  <= amo_new;
              mem_req_mask  <= '1;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= mem_resp_data;
            end
          end
        end
        WR_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (mem_resp_valid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= is_amo(cmd_q) ? old_q : '0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reservation: set by LR return, aged every cycle, cleared by SC, probe or timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
      resv_cnt   <= '0;
    end else if (lr_set) begin
      if (inval_lr) begin
        resv_valid <= 1'b0;
        resv_cnt   <= '0;
      end else begin
        resv_valid <= 1'b1;
        resv_addr  <= word_al(mem_req_addr);
        resv_cnt   <= CNT_W'(LRSC_CYCLES);
      end
    end else if (sc_accept || inval_resv) begin
      resv_valid <= 1'b0;
      resv_cnt   <= '0;
    end else if (resv_valid) begin
      resv_cnt <= resv_cnt - CNT_W'(1);
      if (resv_cnt == CNT_W'(1)) resv_valid <= 1'b0;
    end
  end

endmodule
